// File: rtl/zprize_mul_arb_pkg.sv
// zprize_mul_arb_pkg: shared sizes and the multiplier sideband format
package zprize_mul_arb_pkg;
  localparam int N_REQ = 4;
  localparam int IDW = $clog2(N_REQ);
  localparam int TAG_W = 16;
  typedef struct packed {
    logic vld;
    logic [IDW-1:0] id;
    logic [TAG_W-1:0] tag;
  } mul_sb_t;
endpackage

// File: rtl/zprize_mul_rsp_fifo.sv
// zprize_mul_rsp_fifo: response FIFO with registered head data and valid
module zprize_mul_rsp_fifo #(
  parameter int D = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] wdata,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] rdata
);
  localparam int PW = $clog2(D);
  localparam int KW = $clog2(D + 1);
  logic [DW-1:0] mem [D];
  logic [PW-1:0] wp, rp, rp_n;
  logic [KW-1:0] cnt, cnt_n;
  logic rd;
  assign rd = ready && valid;
  assign rp_n = rd ? (rp == PW'(D - 1) ? '0 : rp + 1'b1) : rp;
  assign cnt_n = cnt + KW'(wr) - KW'(rd);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      valid <= 1'b0;
      rdata <= '0;
    end else begin
      if (wr) wp <= wp == PW'(D - 1) ? '0 : wp + 1'b1;
      rp <= rp_n;
      cnt <= cnt_n;
      valid <= cnt_n != '0;
      // when the queue drains to the incoming word, bypass it straight to the head
      if (cnt_n != '0) rdata <= cnt == KW'(rd) ? wdata : mem[rp_n];
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= wdata;
  assert property (@(posedge clk) disable iff (rst) !(wr && cnt == KW'(D)));
endmodule

// File: rtl/zprize_mul_arbiter.sv
// zprize_mul_arbiter: round-robin, credit-gated sharing of one non-stallable pipelined
// multiplier; results are steered back to per-requester response FIFOs by sideband id.
module zprize_mul_arbiter
  import zprize_mul_arb_pkg::*;
#(
  parameter int N = N_REQ,
  parameter int W = 384,
  parameter int LAT = 12,
  parameter int TAG = TAG_W,
  parameter int D = 4,
  localparam int CW = $clog2(N * D + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N*W-1:0]     req_a,
  input  logic [N*W-1:0]     req_b,
  input  logic [N*TAG-1:0]   req_tag,
  output logic [W-1:0]       mul_in0,
  output logic [W-1:0]       mul_in1,
  output mul_sb_t            mul_m_i,
  input  mul_sb_t            mul_m_o,
  input  logic [2*W-1:0]     mul_out0,
  output logic [N-1:0]       rsp_valid,
  input  logic [N-1:0]       rsp_ready,
  output logic [N*2*W-1:0]   rsp_data,
  output logic [N*TAG-1:0]   rsp_tag,
  output logic [CW-1:0]      inflight
);
  localparam int KW = $clog2(D + 1);
  localparam int FW = $clog2(LAT + 1);
  logic [FW-1:0] flush;
  logic [KW-1:0] credits [N];
  logic [IDW-1:0] rr, gid, idx;
  logic [N-1:0] eligible, grant, pop, wr;
  logic [CW-1:0] pops;
  // scan from the highest offset down so the nearest eligible requester after rr wins
  always_comb begin
    idx = '0;
    gid = rr;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IDW'((int'(rr) + k) % N);
      if (eligible[idx]) gid = idx;
    end
    grant = '0;
    grant[gid] = eligible[gid];
  end
  assign req_ready = grant;
  always_comb begin
    pops = '0;
    for (int i = 0; i < N; i++) pops = pops + CW'(pop[i]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      flush <= FW'(LAT);
      rr <= '0;
      mul_in0 <= '0;
      mul_in1 <= '0;
      mul_m_i <= '0;
      inflight <= '0;
      for (int i = 0; i < N; i++) credits[i] <= KW'(D);
    end else begin
      flush <= flush - FW'(flush != '0);
      if (|grant) begin
        rr <= gid == IDW'(N - 1) ? '0 : gid + 1'b1;
        mul_in0 <= req_a[gid*W +: W];
        mul_in1 <= req_b[gid*W +: W];
      end
      mul_m_i <= {|grant, gid, req_tag[gid*TAG +: TAG]};
      inflight <= inflight + CW'(|grant) - pops;
      for (int i = 0; i < N; i++) credits[i] <= credits[i] - KW'(grant[i]) + KW'(pop[i]);
    end
  for (genvar g = 0; g < N; g++) begin : gen_req
    logic [2*W+TAG-1:0] head;
    assign eligible[g] = req_valid[g] && credits[g] != '0 && flush == '0;
    // stale sideband from before reset drains during the flush window and is dropped
    assign wr[g] = mul_m_o.vld && flush == '0 && mul_m_o.id == IDW'(g);
    assign pop[g] = rsp_valid[g] && rsp_ready[g];
    zprize_mul_rsp_fifo #(.D(D), .DW(2 * W + TAG)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr[g]),
      .wdata ({mul_out0, mul_m_o.tag}),
      .ready (rsp_ready[g]),
      .valid (rsp_valid[g]),
      .rdata (head)
    );
    assign rsp_data[g*2*W +: 2*W] = head[TAG +: 2*W];
    assign rsp_tag[g*TAG +: TAG] = head[TAG-1:0];
    assert property (@(posedge clk) disable iff (rst) credits[g] <= KW'(D));
  end
endmodule

// File: tb/tb_zprize_mul_arbiter.sv
// tb_zprize_mul_arbiter: arbiter against a pipelined multiplier model, checked by a
// queue-based reference of issue order, credits and response timing.
module tb_zprize_mul_arbiter;
  import zprize_mul_arb_pkg::*;
  localparam int N = 4, W = 384, LAT = 12, TAG = 16, D = 4;
  localparam int CW = $clog2(N * D + 1);
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [N*W-1:0] req_a = '0, req_b = '0;
  logic [N*TAG-1:0] req_tag = '0, rsp_tag;
  logic [W-1:0] mul_in0, mul_in1;
  mul_sb_t mul_m_i, mul_m_o;
  logic [2*W-1:0] mul_out0;
  logic [N*2*W-1:0] rsp_data;
  logic [CW-1:0] inflight;
  always #5 clk = ~clk;

  zprize_mul_arbiter #(.N(N), .W(W), .LAT(LAT), .TAG(TAG), .D(D)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .mul_in0(mul_in0), .mul_in1(mul_in1), .mul_m_i(mul_m_i), .mul_m_o(mul_m_o),
    .mul_out0(mul_out0), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .inflight(inflight)
  );

  // Multiplier: no reset; pumps valid-looking junk while rst is high to probe flush masking
  logic [2*W-1:0] pp [LAT];
  mul_sb_t ps [LAT];
  always @(posedge clk) begin
    pp[0] <= mul_in0 * mul_in1;
    ps[0] <= rst ? mul_sb_t'({1'b1, IDW'($urandom), TAG'($urandom)}) : mul_m_i;
    for (int i = 1; i < LAT; i++) begin
      pp[i] <= pp[i-1];
      ps[i] <= ps[i-1];
    end
  end
  assign mul_out0 = pp[LAT-1];
  assign mul_m_o = ps[LAT-1];

  typedef struct { logic [2*W-1:0] p; logic [TAG-1:0] t; int due; } rec_t;
  typedef struct { logic [N-1:0] v; logic [N-1:0] g; } vec_t;
  rec_t q [N][$];
  int outs [N];
  int rr, flush, cyc, checks, errors, acc, n;
  logic [N-1:0] last_rdy;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic randomize_ops();
    for (int k = 0; k < N * W / 32; k++) begin
      req_a[k*32 +: 32] = $urandom;
      req_b[k*32 +: 32] = $urandom;
    end
    req_tag = {$urandom, $urandom};
  endtask

  // Called at a negedge with inputs applied; checks this cycle, advances the model, moves on
  task automatic tick();
    logic [N-1:0] g, ev;
    logic [2*W-1:0] prod;
    int tot, j;
    #1;
    g = '0;
    for (int k = 0; k < N; k++) begin
      j = (rr + k) % N;
      if (g == '0 && req_valid[j] && outs[j] < D && flush == 0) g[j] = 1'b1;
    end
    ev = '0;
    tot = 0;
    for (int i = 0; i < N; i++) begin
      ev[i] = q[i].size() != 0 && q[i][0].due <= cyc;
      tot += outs[i];
    end
    last_rdy = req_ready;
    chk("req_ready", req_ready, g);
    chk("rsp_valid", rsp_valid, ev);
    chk("inflight", inflight, tot);
    for (int i = 0; i < N; i++)
      if (ev[i]) begin
        chk("rsp_data", rsp_data[i*2*W +: 2*W], q[i][0].p);
        chk("rsp_tag", rsp_tag[i*TAG +: TAG], q[i][0].t);
      end
    for (int i = 0; i < N; i++)
      if (g[i]) begin
        prod = {{W{1'b0}}, req_a[i*W +: W]} * {{W{1'b0}}, req_b[i*W +: W]};
        q[i].push_back('{prod, req_tag[i*TAG +: TAG], cyc + LAT + 2});
        outs[i]++;
        rr = (i + 1) % N;
      end
    for (int i = 0; i < N; i++)
      if (ev[i] && rsp_ready[i]) begin
        void'(q[i].pop_front());
        outs[i]--;
      end
    if (flush > 0) flush--;
    acc += $countones(req_ready);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input logic [N-1:0] v, input logic [N-1:0] r, input int cnt);
    acc = 0;
    for (int k = 0; k < cnt; k++) begin
      req_valid = v;
      rsp_ready = r;
      randomize_ops();
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_mul_m_i", mul_m_i, 0);
    chk("rst_mul_in0", mul_in0, 0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      outs[i] = 0;
    end
    rr = 0;
    flush = LAT;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{4'b0000, 4'b0000}; tbl[1] = '{4'b1111, 4'b0001};
    tbl[2] = '{4'b1111, 4'b0010}; tbl[3] = '{4'b0001, 4'b0001};
    tbl[4] = '{4'b1000, 4'b1000}; tbl[5] = '{4'b1010, 4'b0010};
    tbl[6] = '{4'b1011, 4'b1000}; tbl[7] = '{4'b0110, 4'b0010};
    tbl[8] = '{4'b0101, 4'b0100}; tbl[9] = '{4'b0101, 4'b0001};
    checks = 0;
    errors = 0;
    cyc = 0;
    do_reset();
    run(4'b0001, '1, LAT);
    chk("flush_hold", acc, 0);
    run(4'b0001, '1, 1);
    chk("flush_release", acc, 1);

    do_reset();
    run('0, '1, LAT);
    for (int i = 0; i < 10; i++) begin
      req_valid = tbl[i].v;
      rsp_ready = '1;
      randomize_ops();
      tick();
      chk("tbl_grant", last_rdy, tbl[i].g);
    end

    do_reset();
    run('0, '1, LAT);
    req_valid = 4'b0100;
    rsp_ready = '1;
    req_a[2*W +: W] = 3;
    req_b[2*W +: W] = 5;
    req_tag[2*TAG +: TAG] = 16'hBEEF;
    tick();
    req_valid = '0;
    n = 0;
    while (!rsp_valid[2] && n < 40) begin
      tick();
      n++;
    end
    chk("latency", n, LAT + 1);
    chk("single_data", rsp_data[2*2*W +: 2*W], 15);
    chk("single_tag", rsp_tag[2*TAG +: TAG], 16'hBEEF);
    run('1, '1, 2 * N);
    chk("no_bubbles", acc, 2 * N);

    do_reset();
    run('0, '1, LAT);
    run(4'b0010, '0, D + 4);
    chk("credit_limit", acc, D);
    run('0, '0, LAT + 3);
    run('0, 4'b0010, 1);
    run(4'b0010, '0, 4);
    chk("credit_return", acc, 1);
    run('0, '1, LAT + D + 4);
    chk("drained", inflight, 0);

    do_reset();
    run('0, '1, LAT);
    run(4'b0001, '0, 3);
    run('0, '0, LAT + 3);
    run(4'b0001, 4'b0001, 1);
    chk("same_cycle_issue", acc, 1);
    chk("same_cycle_inflight", inflight, 3);
    run(4'b0001, '0, 1);
    chk("credit_kept", acc, 1);
    run(4'b0001, '0, 1);
    chk("credit_exhausted", acc, 0);

    do_reset();
    run('0, '1, LAT);
    run(4'b0111, '0, 3);
    run('0, '0, 2);
    do_reset();
    run('0, '1, LAT + 4);
    chk("flushed_rsp_valid", rsp_valid, 0);
    chk("flushed_inflight", inflight, 0);
    run(4'b0001, '0, D + 2);
    chk("credits_restored", acc, D);

    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset();
      req_valid = N'($urandom);
      rsp_ready = k < 1000 ? N'($urandom) : k < 2000 ? N'($urandom & $urandom) : N'($urandom | $urandom);
      randomize_ops();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
